// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter of NREQ write requesters onto one shared FIFO
// write port. The handshake is zero-latency (ready and write strobe are combinational).
// Optional macro FIFO_ARB_BURST_EN adds burst locking: the winner keeps the port for up
// to BURST_LEN beats.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*DW-1:0]        req_data,
  output logic [NREQ-1:0]           req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [DW-1:0]             fifo_data,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = 4;

`ifdef FIFO_ARB_BURST_EN
  // With BURST_LEN of 1 every lock would end on its first beat, so locking is skipped.
  localparam bit LOCK_EN = (BURST_LEN > 1);
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  typedef enum logic {IDLE, LOCK} state_t;

  state_t        state, state_nx;
  logic [IW-1:0] last_id, last_nx;
  logic [IW-1:0] owner, owner_nx;
  logic [CW-1:0] cnt, cnt_nx;

  logic          rr_hit;
  logic [IW-1:0] rr_idx, cand;
  logic          gnt_hit;
  logic [IW-1:0] gnt_idx;
  logic          xfer;

  // Round-robin search: the first valid requester after last_id wins, wrapping modulo NREQ.
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = '0;
    cand   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last_id) + k) % NREQ);
      if (!rr_hit && req_valid[cand]) begin
        rr_hit = 1'b1;
        rr_idx = cand;
      end
    end
  end

  // Arbitration state, last winner and burst bookkeeping. Reset abandons any burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      last_id <= IW'(NREQ - 1);
      owner   <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nx;
      last_id <= last_nx;
      owner   <= owner_nx;
      cnt     <= cnt_nx;
    end
  end

  // Grant selection, handshake outputs and next-state logic.
  always_comb begin
    state_nx   = state;
    last_nx    = last_id;
    owner_nx   = owner;
    cnt_nx     = cnt;
    gnt_hit    = rr_hit;
    gnt_idx    = rr_idx;
    req_ready  = '0;
    fifo_wr_en = 1'b0;
    fifo_data  = '0;

    // In LOCK only the owner can be granted, even if others are waiting.
    if (state == LOCK) begin
      gnt_idx = owner;
      gnt_hit = req_valid[owner];
    end

    // A full FIFO or an active reset blocks every transfer.
    xfer = gnt_hit && !fifo_full && !rst;

    if (xfer) begin
      req_ready  = NREQ'(1) << gnt_idx;
      fifo_wr_en = 1'b1;
      fifo_data  = req_data[gnt_idx*DW +: DW];
      last_nx    = gnt_idx;
    end

    if (state == LOCK) begin
      if (!req_valid[owner]) begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end else if (xfer) begin
        cnt_nx = cnt + CW'(1);
        if (cnt + CW'(1) == CW'(BURST_LEN)) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
    end else if (xfer && LOCK_EN) begin
      state_nx = LOCK;
      owner_nx = gnt_idx;
      cnt_nx   = CW'(1);
    end
  end

  assign grant_id = last_id;

`ifdef FIFO_ARB_BURST_EN
  assign busy = (state == LOCK);
`else
  assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter with a queue-free behavioural model of the
// round-robin and burst rules. Directed grant-sequence checks run in the default build.
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int BL   = 4;
`ifdef FIFO_ARB_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 fifo_full;
  logic                 fifo_wr_en;
  logic [DW-1:0]        fifo_data;
  logic [1:0]           grant_id;
  logic                 busy;

  int n_chk  = 0;
  int n_fail = 0;

  // model state
  int m_last  = NREQ - 1;
  bit m_lock  = 1'b0;
  int m_owner = 0;
  int m_cnt   = 0;

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_data(fifo_data), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, check the combinational and
  // registered outputs against the model, then advance the model past the next edge.
  task automatic step(input logic r, input logic [NREQ-1:0] v, input logic f);
    int g;
    int c;
    logic [NREQ-1:0] e_rdy;
    logic [DW-1:0]   e_data;
    bit wr;
    @(negedge clk);
    rst       = r;
    req_valid = v;
    fifo_full = f;
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = DW'($urandom);
    #1;
    if (r) begin
      m_last = NREQ - 1;
      m_lock = 1'b0;
      m_cnt  = 0;
    end
    g = -1;
    if (!r) begin
      if (m_lock) begin
        if (v[m_owner]) g = m_owner;
      end else begin
        for (int k = 1; k <= NREQ; k++) begin
          c = (m_last + k) % NREQ;
          if (g < 0 && v[c]) g = c;
        end
      end
    end
    wr     = (g >= 0) && !f;
    e_rdy  = wr ? NREQ'(1 << g) : '0;
    e_data = wr ? req_data[g*DW +: DW] : '0;
    chk("req_ready",  32'(req_ready),  32'(e_rdy));
    chk("fifo_wr_en", 32'(fifo_wr_en), 32'(wr));
    chk("fifo_data",  32'(fifo_data),  32'(e_data));
    chk("grant_id",   32'(grant_id),   32'(m_last));
    chk("busy",       32'(busy),       32'(m_lock));
    if (!r) begin
      if (wr) m_last = g;
      if (m_lock) begin
        if (!v[m_owner]) begin
          m_lock = 1'b0;
          m_cnt  = 0;
        end else if (wr) begin
          m_cnt++;
          if (m_cnt == BL) begin
            m_lock = 1'b0;
            m_cnt  = 0;
          end
        end
      end else if (wr && BURST && BL > 1) begin
        m_lock  = 1'b1;
        m_owner = g;
        m_cnt   = 1;
      end
    end
  endtask

  logic [NREQ-1:0] seq_a [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [NREQ-1:0] seq_b [4] = '{4'b0100, 4'b0001, 4'b0100, 4'b0001};

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; fifo_full = 1'b0;
    step(1'b1, 4'b1111, 1'b0);
    step(1'b1, 4'b0000, 1'b0);

    // all valid: plain round-robin from requester 0
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'b1111, 1'b0);
      if (!BURST) chk("rr_all", 32'(req_ready), 32'(seq_a[i]));
    end
    // two sparse requesters alternate
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'b0101, 1'b0);
      if (!BURST) chk("rr_0101", 32'(req_ready), 32'(seq_b[i]));
    end
    // full stall holds arbitration; sequence resumes at requester 1
    for (int i = 0; i < 3; i++) step(1'b0, 4'b1111, 1'b1);
    step(1'b0, 4'b1111, 1'b0);
    if (!BURST) chk("resume", 32'(req_ready), 32'(4'b0010));
    // idle cycle, then reset mid-traffic
    step(1'b0, 4'b0000, 1'b0);
    step(1'b0, 4'b0011, 1'b0);
    step(1'b0, 4'b0011, 1'b0);
    step(1'b1, 4'b0011, 1'b0);
    step(1'b0, 4'b0011, 1'b0);
    chk("post_rst", 32'(req_ready), 32'(4'b0001));
    // burst pattern and owner drop-out
    for (int i = 0; i < 10; i++) step(1'b0, 4'b0011, 1'b0);
    step(1'b0, 4'b1100, 1'b0);
    step(1'b0, 4'b1100, 1'b0);
    step(1'b0, 4'b1000, 1'b0);
    step(1'b0, 4'b1100, 1'b0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0),
           NREQ'($urandom_range(0, 3) == 0 ? $urandom : ($urandom | $urandom)),
           ($urandom_range(0, 4) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
